// File: rtl/sail_print_stream.sv
// Purpose : multi-channel character-stream merger; per-channel byte FIFOs feed one byte output
//           with whole lines kept together (a channel holds the output until it emits 0x0A or idles out).
// Latency : a beat pushed into an empty FIFO with the output free shows its first byte one edge later.
// Backpr. : in_ready[c] drops unless a worst-case beat (BEATW+1 bytes) fits; the output register holds
//           stable while out_valid && !out_ready.
// Ports   : in_valid/in_ready/in_data/in_len/in_endline are per-channel beat inputs (slice c = channel c);
//           out_valid/out_ready/out_data/out_chan/out_eol are the byte output; timeout_count counts lock
//           releases caused by an idle held channel.
module sail_print_stream #(
    parameter int NCHAN   = 2,
    parameter int BEATW   = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64,
    localparam int LW = $clog2(BEATW + 1),
    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCHAN-1:0]         in_valid,
    output logic [NCHAN-1:0]         in_ready,
    input  logic [NCHAN*BEATW*8-1:0] in_data,
    input  logic [NCHAN*LW-1:0]      in_len,
    input  logic [NCHAN-1:0]         in_endline,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic [CW-1:0]            out_chan,
    output logic                     out_eol,
    output logic [15:0]              timeout_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, HELD} state_t;

    logic [7:0]    mem_q [NCHAN][DEPTH];
    logic [PW-1:0] wr_q  [NCHAN];
    logic [PW-1:0] rd_q  [NCHAN];
    logic [NW-1:0] cnt_q [NCHAN];
    logic [NW-1:0] cnt_d [NCHAN];

    state_t        state_q;
    logic [CW-1:0] held_q;
    logic [CW-1:0] rr_q;
    logic [TW-1:0] idle_q;
    logic [15:0]   tmo_q;
    logic          out_valid_q;
    logic [7:0]    out_data_q;
    logic [CW-1:0] out_chan_q;
    logic          out_eol_q;

    logic [NCHAN-1:0] rdy;
    logic [NCHAN-1:0] acc;
    logic [NW-1:0]    nbyte [NCHAN];
    logic [NW-1:0]    npush [NCHAN];

    logic          load;
    logic          pop;
    logic          sel_ok;
    logic [CW-1:0] sel_ch;
    logic [7:0]    sel_byte;
    int            ch_i;

    assign in_ready      = rdy;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_chan      = out_chan_q;
    assign out_eol       = out_eol_q;
    assign timeout_count = tmo_q;

    // Ready is judged on occupancy before this cycle's pop, so a full beat always fits.
    always_comb begin
        rdy = '0;
        acc = '0;
        for (int c = 0; c < NCHAN; c++) begin
            rdy[c] = (DEPTH - int'(cnt_q[c])) >= (BEATW + 1);
            acc[c] = in_valid[c] && rdy[c];
            if (int'(in_len[c*LW +: LW]) > BEATW) nbyte[c] = NW'(BEATW);
            else                                  nbyte[c] = NW'(in_len[c*LW +: LW]);
            npush[c] = acc[c] ? (nbyte[c] + NW'(in_endline[c])) : '0;
        end
    end

    // Channel selection: a held channel is the only candidate; otherwise round-robin
    // starting after the last granted channel (loop runs backwards so the nearest wins).
    always_comb begin
        load   = !out_valid_q || out_ready;
        sel_ok = 1'b0;
        sel_ch = held_q;
        ch_i   = 0;
        if (state_q == HELD) begin
            sel_ok = (cnt_q[held_q] != '0);
        end else begin
            for (int k = NCHAN; k >= 1; k--) begin
                ch_i = (int'(rr_q) + k) % NCHAN;
                if (cnt_q[ch_i] != '0) begin
                    sel_ok = 1'b1;
                    sel_ch = CW'(ch_i);
                end
            end
        end
        pop      = load && sel_ok;
        sel_byte = mem_q[sel_ch][rd_q[sel_ch]];
    end

    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            cnt_d[c] = cnt_q[c] + npush[c] - NW'(pop && (sel_ch == CW'(c)));
        end
    end

    // Byte storage needs no reset: the pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCHAN; c++) begin
            for (int i = 0; i < BEATW; i++) begin
                if (acc[c] && (i < int'(nbyte[c])))
                    mem_q[c][PW'((int'(wr_q[c]) + i) % DEPTH)] <= in_data[(c*BEATW+i)*8 +: 8];
            end
            if (acc[c] && in_endline[c])
                mem_q[c][PW'((int'(wr_q[c]) + int'(nbyte[c])) % DEPTH)] <= 8'h0A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCHAN; c++) begin
                wr_q[c]  <= '0;
                rd_q[c]  <= '0;
                cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                if (acc[c])
                    wr_q[c] <= PW'((int'(wr_q[c]) + int'(npush[c])) % DEPTH);
                if (pop && (sel_ch == CW'(c)))
                    rd_q[c] <= PW'((int'(rd_q[c]) + 1) % DEPTH);
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            held_q      <= '0;
            rr_q        <= CW'(NCHAN - 1);
            idle_q      <= '0;
            tmo_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_chan_q  <= '0;
            out_eol_q   <= 1'b0;
        end else begin
            if (load) begin
                out_valid_q <= pop;
                if (pop) begin
                    out_data_q <= sel_byte;
                    out_chan_q <= sel_ch;
                    out_eol_q  <= (sel_byte == 8'h0A);
                end
            end
            if (pop) begin
                rr_q    <= sel_ch;
                held_q  <= sel_ch;
                idle_q  <= '0;
                state_q <= (sel_byte == 8'h0A) ? IDLE : HELD;
            end else if ((state_q == HELD) && load && (cnt_q[held_q] == '0)) begin
                // Held channel is starving the output: release the lock after TIMEOUT such cycles.
                if (idle_q == TW'(TIMEOUT - 1)) begin
                    state_q <= IDLE;
                    idle_q  <= '0;
                    if (tmo_q != 16'hFFFF) tmo_q <= tmo_q + 16'd1;
                end else begin
                    idle_q <= idle_q + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sail_print_stream.sv
module tb_sail_print_stream;

    localparam int NCHAN   = 2;
    localparam int BEATW   = 4;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [63:0] in_data;
    logic [5:0]  in_len;
    logic [1:0]  in_endline;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [0:0]  out_chan;
    logic        out_eol;
    logic [15:0] timeout_count;

    sail_print_stream #(.NCHAN(NCHAN), .BEATW(BEATW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_len(in_len), .in_endline(in_endline),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_chan(out_chan), .out_eol(out_eol), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    int chk = 0;
    int err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         chan;
        int         cyc;
    } rx_t;

    logic [7:0] exp_q [2][$];
    rx_t        rx_log [$];
    logic [1:0] last_acc;

    typedef struct {
        int         ch;
        logic [31:0] dat;
        logic [2:0] len;
        logic       eol;
        int         exp_n;
        logic [7:0] exp_last;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: transfers seen at negedge commit at the next posedge.
    initial begin
        logic       stall;
        logic [7:0] p_data;
        logic       p_chan;
        logic       p_eol;
        logic [7:0] e;
        stall = 1'b0; p_data = '0; p_chan = '0; p_eol = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'(out_data), 32'(p_data));
                    check("hold_chan", 32'(out_chan), 32'(p_chan));
                    check("hold_eol", 32'(out_eol), 32'(p_eol));
                end
                if (out_valid && out_ready) begin
                    rx_log.push_back('{out_data, int'(out_chan), cyc});
                    if (exp_q[out_chan].size() == 0) begin
                        check("unexpected_byte", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q[out_chan].pop_front();
                        check("sb_data", 32'(out_data), 32'(e));
                        check("sb_eol", 32'(out_eol), 32'(e == 8'h0A));
                    end
                end
                stall  = out_valid && !out_ready;
                p_data = out_data;
                p_chan = out_chan;
                p_eol  = out_eol;
            end
        end
    end

    task automatic set_beat(input int ch, input logic [31:0] d, input logic [2:0] len, input logic eol);
        in_valid[ch]        = 1'b1;
        in_data[ch*32 +: 32] = d;
        in_len[ch*3 +: 3]   = len;
        in_endline[ch]      = eol;
    endtask

    task automatic clear_in();
        in_valid   = '0;
        in_endline = '0;
    endtask

    // Expected bytes derived from the beat itself: min(len,4) data bytes then optional newline.
    task automatic push_exp(input int ch);
        int nb;
        logic [31:0] d;
        nb = (int'(in_len[ch*3 +: 3]) > BEATW) ? BEATW : int'(in_len[ch*3 +: 3]);
        d  = in_data[ch*32 +: 32];
        for (int i = 0; i < nb; i++) exp_q[ch].push_back(d[i*8 +: 8]);
        if (in_endline[ch]) exp_q[ch].push_back(8'h0A);
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step();
        logic [1:0] a;
        @(negedge clk);
        a = in_valid & in_ready;
        @(posedge clk);
        for (int c = 0; c < 2; c++) if (a[c]) push_exp(c);
        last_acc = a;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_in();
        exp_q[0].delete();
        exp_q[1].delete();
        rx_log.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); i++) step();
        check("drain_q0", exp_q[0].size(), 0);
        check("drain_q1", exp_q[1].size(), 0);
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 300 && rx_log.size() < n; i++) step();
        check("rx_count_reached", 32'(rx_log.size() >= n), 32'd1);
    endtask

    initial begin
        int base;
        int beats;
        int gap;
        logic [31:0] d;

        vecs[0] = '{0, 32'h0000_6968, 3'd2, 1'b1, 3, 8'h0A};
        vecs[1] = '{1, 32'h6463_6261, 3'd4, 1'b1, 5, 8'h0A};
        vecs[2] = '{0, 32'h1122_3344, 3'd0, 1'b0, 0, 8'h00};
        vecs[3] = '{1, 32'h7A79_7877, 3'd7, 1'b0, 4, 8'h7A};
        vecs[4] = '{1, 32'hFFFF_FFFF, 3'd0, 1'b1, 1, 8'h0A};
        vecs[5] = '{0, 32'h0000_0071, 3'd1, 1'b0, 1, 8'h71};
        vecs[6] = '{0, 32'h0074_7372, 3'd3, 1'b1, 4, 8'h0A};
        vecs[7] = '{1, 32'h0000_6E6D, 3'd2, 1'b0, 2, 8'h6E};

        rst_n = 1'b0; in_valid = '0; in_data = '0; in_len = '0; in_endline = '0;
        out_ready = 1'b1; last_acc = '0;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_out_chan", 32'(out_chan), 32'd0);
        check("rst_out_eol", 32'(out_eol), 32'd0);
        check("rst_timeout_count", 32'(timeout_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd3);
        do_reset();
        check("post_rst_in_ready", 32'(in_ready), 32'd3);

        // "hi\n" on ch0: exact cycle-by-cycle shape
        set_beat(0, 32'h0000_6968, 3'd2, 1'b1);
        step();
        check("hi_accepted", 32'(last_acc), 32'd1);
        clear_in();
        @(negedge clk);
        check("hi_lat_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("hi_b0", {out_valid, out_eol, 7'(out_chan), out_data}, {1'b1, 1'b0, 7'd0, 8'h68});
        @(negedge clk);
        check("hi_b1", {out_valid, out_eol, 7'(out_chan), out_data}, {1'b1, 1'b0, 7'd0, 8'h69});
        @(negedge clk);
        check("hi_b2", {out_valid, out_eol, 7'(out_chan), out_data}, {1'b1, 1'b1, 7'd0, 8'h0A});
        @(posedge clk); #1;
        wait_drain();

        // Table-driven beats
        for (int v = 0; v < 8; v++) begin
            base = rx_log.size();
            set_beat(vecs[v].ch, vecs[v].dat, vecs[v].len, vecs[v].eol);
            step();
            check($sformatf("vec%0d_accepted", v), 32'(last_acc[vecs[v].ch]), 32'd1);
            clear_in();
            wait_drain();
            repeat (3) step();
            check($sformatf("vec%0d_nbytes", v), rx_log.size() - base, vecs[v].exp_n);
            if (vecs[v].exp_n > 0) begin
                check($sformatf("vec%0d_last", v), 32'(rx_log[$].data), 32'(vecs[v].exp_last));
                check($sformatf("vec%0d_chan", v), rx_log[$].chan, vecs[v].ch);
            end
        end

        // Both channels push "ab\n" together: ch0 line completes before ch1 starts
        do_reset();
        set_beat(0, 32'h0000_6261, 3'd2, 1'b1);
        set_beat(1, 32'h0000_6261, 3'd2, 1'b1);
        step();
        check("dual_accepted", 32'(last_acc), 32'd3);
        clear_in();
        wait_rx(6);
        wait_drain();
        for (int i = 0; i < 6 && i < rx_log.size(); i++)
            check($sformatf("dual_chan%0d", i), rx_log[i].chan, (i < 3) ? 0 : 1);

        // Lock timeout: ch0 "abc" with no newline, ch1 "x\n" waits behind it
        do_reset();
        set_beat(0, 32'h0063_6261, 3'd3, 1'b0);
        set_beat(1, 32'h0000_0078, 3'd1, 1'b1);
        step();
        clear_in();
        wait_rx(5);
        wait_drain();
        if (rx_log.size() >= 5) begin
            check("tmo_c_chan", rx_log[2].chan, 0);
            check("tmo_x_chan", rx_log[3].chan, 1);
            check("tmo_x_data", 32'(rx_log[3].data), 32'h78);
            gap = rx_log[3].cyc - rx_log[2].cyc;
            check("tmo_gap_range", 32'((gap > TIMEOUT) && (gap <= TIMEOUT + 2)), 32'd1);
        end
        check("tmo_count", 32'(timeout_count), 32'd1);

        // Backpressure: 'z' parked in the output register, ch0 fills until a full beat no longer fits
        do_reset();
        out_ready = 1'b0;
        set_beat(0, 32'h0000_007A, 3'd1, 1'b0);
        step();
        clear_in();
        step();
        check("bp_z_loaded", {out_valid, out_data}, {1'b1, 8'h7A});
        beats = 0;
        for (int b = 0; b < 8; b++) begin
            if (!in_ready[0]) break;
            for (int i = 0; i < 4; i++) d[i*8 +: 8] = 8'(8'h30 + 4*b + i);
            set_beat(0, d, 3'd4, 1'b0);
            step();
            if (last_acc[0]) beats++;
            clear_in();
        end
        check("bp_beats", beats, 3);
        repeat (3) step();
        check("bp_still_stalled", 32'(in_ready[0]), 32'd0);
        check("bp_out_stable", {out_valid, out_data}, {1'b1, 8'h7A});
        out_ready = 1'b1;
        wait_drain();
        check("bp_rx_total", rx_log.size(), 13);

        // Mid-line reset discards everything, including the parked output byte
        do_reset();
        out_ready = 1'b0;
        set_beat(0, 32'h006F_6E6D, 3'd3, 1'b0);
        step();
        clear_in();
        step();
        check("mrst_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_async_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd3);
        exp_q[0].delete();
        exp_q[1].delete();
        rx_log.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        set_beat(0, 32'h0000_0051, 3'd1, 1'b1);
        step();
        clear_in();
        wait_drain();
        repeat (3) step();
        check("mrst_rx_count", rx_log.size(), 2);
        if (rx_log.size() > 0) check("mrst_first", 32'(rx_log[0].data), 32'h51);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
